// File: rtl/calc1_pkg.sv
// Shared calc1 protocol definitions: command and response codes, bus widths,
// and the requester state type.
package calc1_pkg;

  localparam int CMD_W  = 4;
  localparam int DATA_W = 32;
  localparam int RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP1,
    ST_SEND_OP2,
    ST_WAIT_RESP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/calc1_req_initiator_if.sv
// Bundle of the host transaction/result handshake and the calc1 port.
// Handshake rule for both host channels: a transfer happens on a rising edge
// where valid and ready are both 1; the producer holds its payload stable
// while valid is 1 and ready is 0.
// master: the initiator itself.  slave: host plus calc1 side.
interface calc1_req_initiator_if;
  import calc1_pkg::*;

  logic                txn_valid;
  logic                txn_ready;
  logic [CMD_W-1:0]    txn_cmd;
  logic [DATA_W-1:0]   txn_op1;
  logic [DATA_W-1:0]   txn_op2;
  logic [CMD_W-1:0]    req_cmd_out;
  logic [DATA_W-1:0]   req_data_out;
  logic [RESP_W-1:0]   out_resp;
  logic [DATA_W-1:0]   out_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RESP_W-1:0]   rsp_resp;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_timeout;
  logic                rsp_mismatch;
  state_t              dbg_state;

  modport master (
    input  txn_valid, txn_cmd, txn_op1, txn_op2, out_resp, out_data, rsp_ready,
    output txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data,
           rsp_timeout, rsp_mismatch, dbg_state
  );

  modport slave (
    output txn_valid, txn_cmd, txn_op1, txn_op2, out_resp, out_data, rsp_ready,
    input  txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data,
           rsp_timeout, rsp_mismatch, dbg_state
  );

endinterface

// File: rtl/calc1_expect.sv
// Combinational expected-result model for one calc1 transaction.
// Only compiled when CALC1_INIT_CHECK_EN is defined.
`ifdef CALC1_INIT_CHECK_EN
module calc1_expect
  import calc1_pkg::*;
(
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [RESP_W-1:0] exp_resp,
  output logic [DATA_W-1:0] exp_data
);

  logic [DATA_W:0] sum;

  // Evaluate what calc1 should answer for this command.
  always_comb begin
    sum      = {1'b0, op1} + {1'b0, op2};
    exp_resp = RESP_ERR;
    exp_data = '0;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          exp_resp = RESP_OK;
          exp_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          exp_resp = RESP_OK;
          exp_data = op1 - op2;
        end
      end
      CMD_SHL: begin
        exp_resp = RESP_OK;
        exp_data = op1 << op2[4:0];
      end
      CMD_SHR: begin
        exp_resp = RESP_OK;
        exp_data = op1 >> op2[4:0];
      end
      default: begin
        exp_resp = RESP_ERR;
        exp_data = '0;
      end
    endcase
  end

endmodule
`endif

// File: rtl/calc1_req_initiator.sv
// Requester for one calc1 port: takes (cmd, op1, op2) from the host, drives
// the two-beat request, waits for the response with a timeout and hands the
// result back to the host.
// Optional build macro: CALC1_INIT_CHECK_EN adds an expected-result model and
// drives rsp_mismatch; without it rsp_mismatch stays 0.
module calc1_req_initiator
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  c_clk,
  input  logic                  reset,
  calc1_req_initiator_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   op2_q;
  logic                mismatch_q;
  logic                mismatch_next;

`ifdef CALC1_INIT_CHECK_EN
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   op1_q;
  logic [RESP_W-1:0]   exp_resp;
  logic [DATA_W-1:0]   exp_data;

  calc1_expect u_expect (
    .cmd      (cmd_q),
    .op1      (op1_q),
    .op2      (op2_q),
    .exp_resp (exp_resp),
    .exp_data (exp_data)
  );

  // Compare the live calc1 answer with the model; only used on capture.
  always_comb begin
    mismatch_next = (bus.out_resp != exp_resp) ||
                    ((bus.out_resp == RESP_OK) && (bus.out_data != exp_data));
  end
`else
  // No model built: the mismatch flag can never be raised.
  always_comb begin
    mismatch_next = 1'b0;
  end
`endif

  assign bus.rsp_mismatch = mismatch_q;
  assign bus.dbg_state    = state;

  // Transaction FSM; all host and calc1 outputs are registered and are set
  // on the edge that enters the state they belong to.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      op2_q            <= '0;
`ifdef CALC1_INIT_CHECK_EN
      cmd_q            <= '0;
      op1_q            <= '0;
`endif
      bus.txn_ready    <= 1'b0;
      bus.req_cmd_out  <= '0;
      bus.req_data_out <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_resp     <= '0;
      bus.rsp_data     <= '0;
      bus.rsp_timeout  <= 1'b0;
      mismatch_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.txn_valid && bus.txn_ready) begin
            op2_q            <= bus.txn_op2;
`ifdef CALC1_INIT_CHECK_EN
            cmd_q            <= bus.txn_cmd;
            op1_q            <= bus.txn_op1;
`endif
            bus.txn_ready    <= 1'b0;
            bus.req_cmd_out  <= bus.txn_cmd;
            bus.req_data_out <= bus.txn_op1;
            state            <= ST_SEND_OP1;
          end else begin
            // Also raises ready on the first cycle out of reset.
            bus.txn_ready    <= 1'b1;
          end
        end
        ST_SEND_OP1: begin
          bus.req_cmd_out  <= '0;
          bus.req_data_out <= op2_q;
          state            <= ST_SEND_OP2;
        end
        ST_SEND_OP2: begin
          bus.req_data_out <= '0;
          cnt              <= '0;
          state            <= ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (bus.out_resp != RESP_NONE) begin
            bus.rsp_resp    <= bus.out_resp;
            bus.rsp_data    <= bus.out_data;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            mismatch_q      <= mismatch_next;
            state           <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.rsp_resp    <= RESP_NONE;
            bus.rsp_data    <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            mismatch_q      <= 1'b0;
            state           <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Ready to the host only returns after handoff, never same cycle.
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            mismatch_q      <= 1'b0;
            bus.txn_ready   <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/calc1_req_initiator.md
Name: calc1_req_initiator

Overview:
- Synthesizable requester for one calc1 request port: the initiator side of the calc1 cmd/data -> resp/data protocol.
- Accepts one transaction (cmd, op1, op2) from a host valid/ready interface, sequences it onto the calc1 port, waits for the response, and returns resp/data to the host.
- One instance per calc1 port. Used both as an on-chip client and as the bus-functional driver in calc1 benches.

Parameters:
- TIMEOUT_CYCLES, 16: WAIT_RESP cycles allowed before the transaction is aborted as timed out.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- c_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- txn_valid  in  1  host presents a transaction.
- txn_ready  out  1  initiator can accept a transaction.
- txn_cmd  in  4  calc1 command (1 add, 2 sub, 5 shl, 6 shr; others passed through).
- txn_op1  in  32  first operand.
- txn_op2  in  32  second operand.
- req_cmd_out  out  4  to calc1 reqN_cmd_in.
- req_data_out  out  32  to calc1 reqN_data_in.
- out_resp  in  2  from calc1 out_respN.
- out_data  in  32  from calc1 out_dataN.
- rsp_valid  out  1  result available to host.
- rsp_ready  in  1  host consumes the result.
- rsp_resp  out  2  captured calc1 response code.
- rsp_data  out  32  captured calc1 result data.
- rsp_timeout  out  1  transaction timed out.
- rsp_mismatch  out  1  self-check failure (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 (txn_ready = 0 during reset), state IDLE, counter 0. Reset mid-transaction abandons the transaction with no response to the host. The calc1 port sees cmd 0 from the cycle after reset is asserted.
- States: IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, DONE.
- IDLE:
  - txn_ready = 1; req_cmd_out = 0; req_data_out = 0.
  - On txn_valid && txn_ready, register cmd/op1/op2 and go to SEND_OP1.
- SEND_OP1 (1 cycle): req_cmd_out = cmd, req_data_out = op1; go to SEND_OP2.
- SEND_OP2 (1 cycle): req_cmd_out = 0, req_data_out = op2; clear counter; go to WAIT_RESP.
- WAIT_RESP:
  - req_cmd_out = 0, req_data_out = 0.
  - out_resp is sampled every cycle.
  - If out_resp != 0: capture rsp_resp = out_resp and rsp_data = out_data; go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: set rsp_resp = 0, rsp_data = 0, rsp_timeout = 1; go to DONE.
  - Otherwise increment the counter.
- DONE:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, rsp_timeout and rsp_mismatch; go to IDLE.
- Same-cycle accept: txn_ready is 0 in DONE, so a new transaction can only be accepted on the cycle after handoff. This gives a minimum 5-cycle period per transaction.
- Response codes: any nonzero out_resp is captured verbatim (1 success, 2 overflow/underflow/invalid command, 3 reserved). out_resp is ignored outside WAIT_RESP.
- Late responses arriving after a timeout are dropped.
- txn_cmd = 0 is sent as-is. calc1 gives no response, so this ends in a timeout.

Optional Feature:
- Macro: CALC1_INIT_CHECK_EN.
- With the macro: an expected-result model evaluates the registered transaction and compares it in DONE.
  - Add: expected resp 2 if op1+op2 carries out of 32 bits, else resp 1 with the 32-bit sum.
  - Sub: expected resp 2 if op2 > op1, else resp 1 with op1-op2.
  - Shift left/right: logical shift of op1 by the 5 LSBs of op2; resp 1.
  - Any other nonzero cmd: expected resp 2.
  - rsp_mismatch = 1 in DONE if resp differs, or if resp == 1 and data differs. Timeouts never set rsp_mismatch.
- Without the macro: rsp_mismatch is tied to 0 and no model logic is built.

Decomposition:
- Shared package calc1_pkg holds:
  - CMD_NOP/ADD/SUB/SHL/SHR constants;
  - RESP_NONE/OK/ERR constants;
  - CMD_W = 4, DATA_W = 32, RESP_W = 2;
  - the state enum type.
- Sub-module calc1_expect: combinational expected-result model, instantiated only under CALC1_INIT_CHECK_EN.

Test Plan:
- add 1h + 1FF_FFFFh, calc1 returns resp 1 data 200_0000h -> req_cmd_out 1 then 0, rsp_resp 1, rsp_data 0200_0000h, rsp_mismatch 0.
- add FFFF_FFFFh + 1 -> calc1 resp 2; rsp_resp 2, rsp_timeout 0, rsp_mismatch 0 with the check enabled.
- cmd 3 op1 1 op2 0 -> rsp_resp 2. Stub with no response -> rsp_timeout 1 exactly 16 cycles after SEND_OP2, rsp_resp 0.
- sub 1 - Fh -> rsp_resp 2. Hold rsp_ready low 10 cycles -> rsp_valid and rsp_* stay stable and txn_ready stays 0.
- Reset asserted mid-WAIT_RESP -> next cycle all outputs 0 and txn_ready 0. After reset release, a shl 1<<4 transaction gives rsp_data 10h and resp 1.
- Stub returns wrong data 5 for add 2+2 -> rsp_mismatch 1 with CALC1_INIT_CHECK_EN, 0 without.
